// File: rtl/gradient_map_pkg.sv
// Shared definitions for the gradient-map classifier path: streamer FSM states and
// map/feature geometry defaults used by the streamer, classifier and map accumulator.
package gradient_map_pkg;
    localparam int GM_NUM_CELLS  = 1024;
    localparam int GM_VALUE_BITS = 8;
    localparam int GM_MAP_BITS   = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_WAIT
    } streamer_state_t;
endpackage

// File: rtl/feature_streamer_if.sv
// Map RAM port plus classifier stream as seen by the feature streamer.
// master = streamer side, slave = RAM/classifier side.
interface feature_streamer_if
    import gradient_map_pkg::*;
#(
    parameter int NUM_CELLS  = GM_NUM_CELLS,
    parameter int MAP_BITS   = GM_MAP_BITS,
    parameter int VALUE_BITS = GM_VALUE_BITS
);
    localparam int AW = $clog2(NUM_CELLS);

    logic                  map_rd_en;
    logic [AW-1:0]         map_rd_addr;
    logic [MAP_BITS-1:0]   map_rd_data;
    logic                  map_wr_en;
    logic [AW-1:0]         map_wr_addr;
    logic [MAP_BITS-1:0]   map_wr_data;
    logic                  start;
    logic [VALUE_BITS-1:0] feature_out;
    logic                  result_valid;

    modport master (
        output map_rd_en, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
        output start, feature_out,
        input  map_rd_data, result_valid
    );

    modport slave (
        input  map_rd_en, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
        input  start, feature_out,
        output map_rd_data, result_valid
    );
endinterface

// File: rtl/map_cell_scaler.sv
// Combinational per-cell scaler: saturated feature and decayed write-back value
// from one stored map cell.
module map_cell_scaler
    import gradient_map_pkg::*;
#(
    parameter int MAP_BITS    = GM_MAP_BITS,
    parameter int VALUE_BITS  = GM_VALUE_BITS,
    parameter int FEAT_SHIFT  = 4,
    parameter int DECAY_SHIFT = 1
) (
    input  logic [MAP_BITS-1:0]   m,
    output logic [VALUE_BITS-1:0] feature,
    output logic [MAP_BITS-1:0]   decayed
);
    localparam int FEAT_MAX = (1 << VALUE_BITS) - 1;

    logic [MAP_BITS-1:0] shifted;

    assign shifted = m >> FEAT_SHIFT;
    assign feature = (32'(shifted) > FEAT_MAX) ? '1 : VALUE_BITS'(shifted);

    // m >> s never exceeds m, so the subtraction cannot underflow
    if (DECAY_SHIFT == 0) begin : g_clear
        assign decayed = '0;
    end else begin : g_decay
        assign decayed = m - (m >> DECAY_SHIFT);
    end
endmodule

// File: rtl/feature_streamer.sv
// Reads the whole gradient map per inference tick, streams one saturated feature per
// cycle to the classifier with a start pulse, and writes a decayed value back per cell.
module feature_streamer
    import gradient_map_pkg::*;
#(
    parameter int NUM_CELLS    = GM_NUM_CELLS,
    parameter int MAP_BITS     = GM_MAP_BITS,
    parameter int VALUE_BITS   = GM_VALUE_BITS,
    parameter int FEAT_SHIFT   = 4,
    parameter int DECAY_SHIFT  = 1,
    parameter int INFER_PERIOD = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               trigger,
    feature_streamer_if.master bus,
    output logic               busy,
    output logic [7:0]         dropped_cnt
);
    localparam int AW     = $clog2(NUM_CELLS);
    localparam int TW     = $clog2(INFER_PERIOD);
    localparam int STAGES = 2;

    streamer_state_t       state;
    logic [TW-1:0]         timer;
    logic                  tick;
    logic                  req;
    logic                  pending;
    logic                  flush_cnt;
    logic [STAGES:0]       vld_pipe;
    logic [AW-1:0]         addr_d1;
    logic [VALUE_BITS-1:0] feat_c;
    logic [MAP_BITS-1:0]   decay_c;

    assign tick = enable && (timer == TW'(INFER_PERIOD - 1));
    assign req  = enable && (tick || trigger);

    // vld_pipe[0] is the read strobe, vld_pipe[STAGES] the write-back strobe
    assign bus.map_rd_en = vld_pipe[0];
    assign bus.map_wr_en = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (!enable || tick)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            pending         <= 1'b0;
            dropped_cnt     <= '0;
            flush_cnt       <= 1'b0;
            vld_pipe        <= '0;
            bus.map_rd_addr <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // one request may wait behind the running frame; further ones are counted
            if (state != S_IDLE && req) begin
                if (!pending)
                    pending <= 1'b1;
                else if (dropped_cnt != 8'hFF)
                    dropped_cnt <= dropped_cnt + 1'b1;
            end
            case (state)
                S_IDLE: if (req || pending) begin
                    state           <= S_READ;
                    busy            <= 1'b1;
                    pending         <= 1'b0;
                    vld_pipe[0]     <= 1'b1;
                    bus.map_rd_addr <= '0;
                end
                S_READ: begin
                    if (bus.map_rd_addr == AW'(NUM_CELLS - 1)) begin
                        state           <= S_FLUSH;
                        vld_pipe[0]     <= 1'b0;
                        bus.map_rd_addr <= '0;
                        flush_cnt       <= 1'b0;
                    end else begin
                        bus.map_rd_addr <= bus.map_rd_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt)
                        state <= S_WAIT;
                    flush_cnt <= 1'b1;
                end
                S_WAIT: if (bus.result_valid) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    map_cell_scaler #(
        .MAP_BITS   (MAP_BITS),
        .VALUE_BITS (VALUE_BITS),
        .FEAT_SHIFT (FEAT_SHIFT),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_scaler (
        .m      (bus.map_rd_data),
        .feature(feat_c),
        .decayed(decay_c)
    );

    // read data is valid in stage 1; feature and write-back register together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_d1         <= '0;
            bus.start       <= 1'b0;
            bus.feature_out <= '0;
            bus.map_wr_addr <= '0;
            bus.map_wr_data <= '0;
        end else begin
            addr_d1   <= bus.map_rd_addr;
            bus.start <= vld_pipe[1] && (addr_d1 == '0);
            if (vld_pipe[1]) begin
                bus.feature_out <= feat_c;
                bus.map_wr_addr <= addr_d1;
                bus.map_wr_data <= decay_c;
            end
        end
    end
endmodule

// File: tb/tb_feature_streamer.sv
// Directed bench for feature_streamer: ramp and saturated maps, overlap/drop handling,
// periodic ticks, mid-stream reset and enable gating, on two parameterisations.
module tb_feature_streamer;
    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en1, en2, trig1, trig2;
    logic       busy1, busy2;
    logic [7:0] drop1, drop2;
    logic [1:0] fill1, fill2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start1_cnt = 0;
    int start2_cnt = 0;
    int wr1_cnt = 0;

    feature_streamer_if #(.NUM_CELLS(N), .MAP_BITS(12), .VALUE_BITS(8)) io1 ();
    feature_streamer_if #(.NUM_CELLS(N), .MAP_BITS(12), .VALUE_BITS(8)) io2 ();

    feature_streamer #(
        .NUM_CELLS(N), .MAP_BITS(12), .VALUE_BITS(8), .FEAT_SHIFT(4),
        .DECAY_SHIFT(1), .INFER_PERIOD(100000)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .trigger(trig1),
        .bus(io1), .busy(busy1), .dropped_cnt(drop1)
    );

    feature_streamer #(
        .NUM_CELLS(N), .MAP_BITS(12), .VALUE_BITS(8), .FEAT_SHIFT(4),
        .DECAY_SHIFT(0), .INFER_PERIOD(64)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .trigger(trig2),
        .bus(io2), .busy(busy2), .dropped_cnt(drop2)
    );

    // map RAMs: 1-cycle read latency, write-back applied, fill 1 = k*37, fill 2 = all 4095
    logic [11:0] mem1 [N];
    logic [11:0] mem2 [N];

    always @(posedge clk) begin
        if (io1.map_rd_en) io1.map_rd_data <= mem1[io1.map_rd_addr];
        if (io2.map_rd_en) io2.map_rd_data <= mem2[io2.map_rd_addr];
        if (fill1 == 2'd1)      for (int k = 0; k < N; k++) mem1[k] <= 12'(k * 37);
        else if (fill1 == 2'd2) for (int k = 0; k < N; k++) mem1[k] <= 12'hFFF;
        else if (io1.map_wr_en) mem1[io1.map_wr_addr] <= io1.map_wr_data;
        if (fill2 == 2'd2)      for (int k = 0; k < N; k++) mem2[k] <= 12'hFFF;
        else if (io2.map_wr_en) mem2[io2.map_wr_addr] <= io2.map_wr_data;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io1.start)     start1_cnt <= start1_cnt + 1;
        if (io2.start)     start2_cnt <= start2_cnt + 1;
        if (io1.map_wr_en) wr1_cnt    <= wr1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rv1();
        io1.result_valid = 1'b1;
        step();
        io1.result_valid = 1'b0;
    endtask

    initial begin
        int m, fe, de, prev, s1, s2, w1;
        rst_n = 1'b0; en1 = 1'b1; en2 = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
        io1.result_valid = 1'b0; io2.result_valid = 1'b0;
        fill1 = 2'd0; fill2 = 2'd0;
        #22;
        chk("rst_rd_en",   io1.map_rd_en, 0);
        chk("rst_rd_addr", io1.map_rd_addr, 0);
        chk("rst_wr_en",   io1.map_wr_en, 0);
        chk("rst_wr_addr", io1.map_wr_addr, 0);
        chk("rst_wr_data", io1.map_wr_data, 0);
        chk("rst_start",   io1.start, 0);
        chk("rst_feature", io1.feature_out, 0);
        chk("rst_busy",    busy1, 0);
        chk("rst_dropped", drop1, 0);
        chk("rst_busy2",   busy2, 0);
        fill1 = 2'd1; fill2 = 2'd2;
        step();
        fill1 = 2'd0; fill2 = 2'd0;
        @(negedge clk) rst_n = 1'b1;
        step(2);

        // periodic ticks on dut2, result returned 3 cycles after each stream
        en2 = 1'b1;
        prev = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 80 && !io2.start; i++) step();
            chk("per_start_seen", io2.start, 1);
            if (f == 0) begin
                chk("sat_feature_ds0", io2.feature_out, 255);
                chk("sat_wrdata_ds0",  io2.map_wr_data, 0);
                chk("sat_wren_ds0",    io2.map_wr_en, 1);
            end else begin
                chk("per_period", cyc - prev, 64);
            end
            prev = cyc;
            step(16);
            step(2);
            io2.result_valid = 1'b1;
            step();
            io2.result_valid = 1'b0;
            chk("per_idle", busy2, 0);
        end
        chk("per_dropped", drop2, 0);
        en2 = 1'b0;

        // ramp map k*37 on dut1, single trigger
        trig1 = 1'b1; step(); trig1 = 1'b0;
        chk("t1_rd_en",   io1.map_rd_en, 1);
        chk("t1_rd_addr", io1.map_rd_addr, 0);
        chk("t1_busy",    busy1, 1);
        chk("t1_start",   io1.start, 0);
        step();
        chk("t2_rd_addr", io1.map_rd_addr, 1);
        chk("t2_start",   io1.start, 0);
        step();
        for (int k = 0; k < N; k++) begin
            m  = k * 37;
            fe = ((m >> 4) > 255) ? 255 : (m >> 4);
            de = m - (m >> 1);
            chk("ramp_start",   io1.start, (k == 0) ? 1 : 0);
            chk("ramp_feature", io1.feature_out, fe);
            chk("ramp_wr_en",   io1.map_wr_en, 1);
            chk("ramp_wr_addr", io1.map_wr_addr, k);
            chk("ramp_wr_data", io1.map_wr_data, de);
            if (k + 2 < N) chk("ramp_rd_addr", io1.map_rd_addr, k + 2);
            step();
        end
        chk("end_wr_en",    io1.map_wr_en, 0);
        chk("end_rd_en",    io1.map_rd_en, 0);
        chk("end_feat_hold", io1.feature_out, 34);
        chk("end_busy",     busy1, 1);
        chk("mem15_decay",  mem1[15], 278);
        step(3);
        pulse_rv1();
        chk("ramp_idle", busy1, 0);

        // saturation: 4095 -> feature 255, write-back 2048
        fill1 = 2'd2; step(); fill1 = 2'd0;
        trig1 = 1'b1; step(); trig1 = 1'b0;
        step(2);
        chk("sat_start",   io1.start, 1);
        chk("sat_feature", io1.feature_out, 255);
        chk("sat_wr_data", io1.map_wr_data, 2048);
        step(16);
        pulse_rv1();
        chk("sat_idle", busy1, 0);

        // overlap: triggers at T0, T5, T8
        trig1 = 1'b1; step(); trig1 = 1'b0;
        step(4);
        trig1 = 1'b1; step(); trig1 = 1'b0;
        chk("ovl_pending", u_dut1.pending, 1);
        chk("ovl_drop0",   drop1, 0);
        step(2);
        trig1 = 1'b1; step(); trig1 = 1'b0;
        chk("ovl_drop1", drop1, 1);
        step(10);
        chk("ovl_wait_busy", busy1, 1);
        pulse_rv1();
        chk("ovl_r1_start", io1.start, 0);
        chk("ovl_r1_busy",  busy1, 0);
        step(2);
        chk("ovl_r3_start", io1.start, 0);
        chk("ovl_r3_busy",  busy1, 1);
        step();
        chk("ovl_r4_start", io1.start, 1);
        step(16);
        chk("ovl_pend_clr", u_dut1.pending, 0);
        pulse_rv1();
        chk("ovl_idle",    busy1, 0);
        chk("ovl_drop_keep", drop1, 1);

        // reset mid-stream at T3+7
        trig1 = 1'b1; step(); trig1 = 1'b0;
        step(2);
        chk("rms_start", io1.start, 1);
        step(7);
        rst_n = 1'b0;
        #1;
        chk("rms_rd_en",   io1.map_rd_en, 0);
        chk("rms_rd_addr", io1.map_rd_addr, 0);
        chk("rms_wr_en",   io1.map_wr_en, 0);
        chk("rms_wr_addr", io1.map_wr_addr, 0);
        chk("rms_wr_data", io1.map_wr_data, 0);
        chk("rms_feature", io1.feature_out, 0);
        chk("rms_busy",    busy1, 0);
        chk("rms_dropped", drop1, 0);
        s1 = start1_cnt; w1 = wr1_cnt;
        step(2);
        @(negedge clk) rst_n = 1'b1;
        step(30);
        chk("rms_no_start", start1_cnt - s1, 0);
        chk("rms_no_wr",    wr1_cnt - w1, 0);
        chk("rms_idle",     busy1, 0);

        // enable low: trigger and ticks ignored
        en1 = 1'b0;
        s1 = start1_cnt; s2 = start2_cnt;
        trig1 = 1'b1; trig2 = 1'b1; step(); trig1 = 1'b0; trig2 = 1'b0;
        step(80);
        chk("dis_start1", start1_cnt - s1, 0);
        chk("dis_start2", start2_cnt - s2, 0);
        chk("dis_busy1",  busy1, 0);
        chk("dis_busy2",  busy2, 0);

        // enable dropped mid-frame: frame still completes
        en1 = 1'b1;
        w1 = wr1_cnt;
        trig1 = 1'b1; step(); trig1 = 1'b0;
        step(4);
        en1 = 1'b0;
        step(20);
        chk("midoff_wr_cnt", wr1_cnt - w1, 16);
        chk("midoff_wait",   busy1, 1);
        pulse_rv1();
        chk("midoff_idle",   busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/feature_streamer.md
# feature_streamer

Upstream sequencer for the gradient-map classifier: on each inference tick it reads the full gradient map from its RAM read port and scales each cell to a classifier feature. It issues the classifier `start` pulse and delivers exactly one feature per cycle in cell order, writing a decayed value back to each cell as it goes. It then holds off until the classifier reports `result_valid` before arming the next frame.

## Interface
- `NUM_CELLS`, 1024: cells per map and features per frame.
- `MAP_BITS`, 12: stored map cell width (unsigned).
- `VALUE_BITS`, 8: feature width delivered to the classifier.
- `FEAT_SHIFT`, 4: right shift applied before saturation to `VALUE_BITS`.
- `DECAY_SHIFT`, 1: write-back decay; 0 means clear the cell.
- `INFER_PERIOD`, 1000000: cycles between periodic ticks (≥ NUM_CELLS+8).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: gates the tick timer and `trigger`. An in-flight frame always completes.
- `trigger` in 1: one-cycle forced inference request.
- `map_rd_en` out 1: map RAM read strobe.
- `map_rd_addr` out $clog2(NUM_CELLS): read address.
- `map_rd_data` in MAP_BITS: valid the cycle after `map_rd_en`.
- `map_wr_en` out 1: decay write-back strobe.
- `map_wr_addr` out $clog2(NUM_CELLS): write-back address.
- `map_wr_data` out MAP_BITS: decayed value.
- `start` out 1: one-cycle pulse to the classifier, coincident with feature 0.
- `feature_out` out VALUE_BITS: feature stream to the classifier.
- `result_valid` in 1: classifier completion pulse.
- `busy` out 1: high whenever state ≠ S_IDLE.
- `dropped_cnt` out 8: saturating count of discarded requests.

## Operation
- States:
  - S_IDLE → S_READ on request.
  - S_READ issues addresses 0..NUM_CELLS-1, then → S_FLUSH.
  - S_FLUSH lets the pipeline drain for 2 cycles, then → S_WAIT.
  - S_WAIT → S_IDLE on `result_valid`.
- Request = timer tick OR `trigger`, qualified by `enable`.
- Timer runs in all states while `enable` is high, wraps at INFER_PERIOD-1, and is held at 0 while `enable` is low.
- Request while not S_IDLE: set the one-deep `pending` flag. If `pending` is already set, increment `dropped_cnt`, saturating at 255.
- Tick and `trigger` in the same cycle count as one request.
- S_IDLE with `pending` set: consume it as a request and clear `pending`.
- Feature: min(m >> FEAT_SHIFT, 2^VALUE_BITS-1), with m unsigned.
- Decay: m - (m >> DECAY_SHIFT), or 0 if DECAY_SHIFT = 0. The result never underflows.
- `result_valid` outside S_WAIT is ignored.
- Map updates from the event path landing on cell k between its read and its write-back are overwritten. This loss is accepted.
- Reset values:
  - All outputs 0.
  - State S_IDLE, timer 0, `pending` 0.
  - Reset mid-frame aborts immediately; no further `start`.

## Timing
- T0: request accepted in S_IDLE.
- Read pipeline: `map_rd_en` = 1 and `map_rd_addr` = k during T1+k, for k = 0..NUM_CELLS-1.
- Data: `map_rd_data` holds m[k] at T2+k.
- Classifier side: `feature_out` = f[k] at T3+k, and `start` = 1 only at T3.
- Write-back: `map_wr_en` = 1, `map_wr_addr` = k, `map_wr_data` = decay(m[k]) at T3+k.
- All outputs are registered; `feature_out` holds its last value outside the stream.
- S_WAIT is entered at T3+NUM_CELLS. `result_valid` at cycle Tr returns the block to S_IDLE at Tr+1.
- Earliest next `start` is at Tr+4.

## Structure
- Shared package `gradient_map_pkg` holds:
  - the `streamer_state_t` enum;
  - `NUM_CELLS`, `VALUE_BITS` and `MAP_BITS` defaults, shared with the classifier and the map accumulator.
- Sub-module `map_cell_scaler` is the combinational scaler. It takes m and returns both the feature and the decay value.
- Control, timer, counters and pipeline registers stay in `feature_streamer`.

## Test plan
- Map m[k] = k*37 mod 4096, NUM_CELLS = 16, trigger once:
  - `start` at T3;
  - `feature_out` sequence min((k*37) >> 4, 255) on consecutive cycles;
  - 16 write-backs with value m - (m >> 1).
- Saturation: m = 4095 gives feature 255 and write-back 2048. With DECAY_SHIFT = 0 the write-back is 0.
- Overlap: `trigger` at T0, T5 and T8 during a frame:
  - `pending` is set;
  - `dropped_cnt` = 1;
  - the second frame starts 4 cycles after `result_valid`.
- Periodic mode: INFER_PERIOD = 64, `enable` = 1, `result_valid` returned 3 cycles after the stream:
  - one `start` every 64 cycles;
  - `dropped_cnt` stays 0.
- Reset mid-stream: assert `rst_n` = 0 at T3+7:
  - all outputs 0 asynchronously;
  - no further `start` or write-backs;
  - after release, the block is idle until a new request.
- `enable` = 0: ticks and `trigger` are ignored. Lowering `enable` mid-frame lets the frame complete.
